// File: rtl/core_ctrl_if.sv
// Handshake, decode and status bundle between core_ctrl and the memory ports and IDU/EXU.
// master is the sequencer side; slave is the memories/datapath side.
interface core_ctrl_if #(
   parameter int unsigned XLEN = 32
);
   logic            imem_req;
   logic            imem_gnt;
   logic            imem_rvalid;
   logic            ir_load;
   logic            dec_rd_we;
   logic            dec_load;
   logic            dec_store;
   logic            dec_ebreak;
   logic            dec_illegal;
   logic            exu_pc_branch;
   logic [XLEN-1:0] exu_target_pc;
   logic            dmem_req;
   logic            dmem_we;
   logic            dmem_gnt;
   logic            dmem_rvalid;
   logic            rf_we;
   logic            rd_sel_mem;
   logic [XLEN-1:0] pc;
   logic            instret;
   logic            halted;
   logic [1:0]      trap_cause;

   modport master (
      output imem_req, ir_load, dmem_req, dmem_we, rf_we, rd_sel_mem,
             pc, instret, halted, trap_cause,
      input  imem_gnt, imem_rvalid, dec_rd_we, dec_load, dec_store,
             dec_ebreak, dec_illegal, exu_pc_branch, exu_target_pc,
             dmem_gnt, dmem_rvalid
   );

   modport slave (
      input  imem_req, ir_load, dmem_req, dmem_we, rf_we, rd_sel_mem,
             pc, instret, halted, trap_cause,
      output imem_gnt, imem_rvalid, dec_rd_we, dec_load, dec_store,
             dec_ebreak, dec_illegal, exu_pc_branch, exu_target_pc,
             dmem_gnt, dmem_rvalid
   );
endinterface

// File: rtl/core_ctrl.sv
// Multi-cycle sequencer for the single-issue core: owns the PC and orders
// instruction fetch, execute, data-memory access and retirement.
module core_ctrl #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
   input logic         clk,
   input logic         rst,
   core_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      S_FETCH    = 3'd0,
      S_WAIT_IR  = 3'd1,
      S_EXEC     = 3'd2,
      S_MEM      = 3'd3,
      S_WAIT_MEM = 3'd4,
      S_HALT     = 3'd5
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [1:0]      trap_cause_q, trap_cause_d;
   logic [XLEN-1:0] pc_inc;
   logic [XLEN-1:0] jmp_pc;
   logic            ir_load_c;
   logic            rf_we_c;
   logic            rd_sel_mem_c;
   logic            instret_c;

   assign pc_inc = pc_q + XLEN'(4);
   assign jmp_pc = {bus.exu_target_pc[XLEN-1:1], 1'b0};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_PC;
         trap_cause_q <= 2'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         trap_cause_q <= trap_cause_d;
      end
   end

   // Next state, PC update and the handshake-qualified strobes.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      trap_cause_d = trap_cause_q;
      ir_load_c    = 1'b0;
      rf_we_c      = 1'b0;
      rd_sel_mem_c = 1'b0;
      instret_c    = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (bus.imem_gnt) state_d = S_WAIT_IR;
         end
         S_WAIT_IR: begin
            if (bus.imem_rvalid) begin
               ir_load_c = 1'b1;
               state_d   = S_EXEC;
            end
         end
         S_EXEC: begin
            if (bus.dec_illegal) begin
               trap_cause_d = 2'd2;
               state_d      = S_HALT;
            end else if (bus.dec_ebreak) begin
               trap_cause_d = 2'd1;
               state_d      = S_HALT;
            end else if (bus.dec_load || bus.dec_store) begin
               state_d = S_MEM;
            end else if (bus.exu_pc_branch && bus.exu_target_pc[1]) begin
               trap_cause_d = 2'd3;
               state_d      = S_HALT;
            end else begin
               rf_we_c   = bus.dec_rd_we;
               instret_c = 1'b1;
               pc_d      = bus.exu_pc_branch ? jmp_pc : pc_inc;
               state_d   = S_FETCH;
            end
         end
         S_MEM: begin
            if (bus.dmem_gnt) begin
               if (bus.dec_store) begin
                  instret_c = 1'b1;
                  pc_d      = pc_inc;
                  state_d   = S_FETCH;
               end else begin
                  state_d = S_WAIT_MEM;
               end
            end
         end
         S_WAIT_MEM: begin
            if (bus.dmem_rvalid) begin
               rf_we_c      = bus.dec_rd_we;
               rd_sel_mem_c = 1'b1;
               instret_c    = 1'b1;
               pc_d         = pc_inc;
               state_d      = S_FETCH;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Requests decode from state; masked during reset since the reset state is FETCH.
   assign bus.imem_req   = !rst && (state_q == S_FETCH);
   assign bus.dmem_req   = !rst && (state_q == S_MEM);
   assign bus.dmem_we    = !rst && (state_q == S_MEM) && bus.dec_store;
   assign bus.ir_load    = ir_load_c;
   assign bus.rf_we      = rf_we_c;
   assign bus.rd_sel_mem = rd_sel_mem_c;
   assign bus.instret    = instret_c;
   assign bus.pc         = pc_q;
   assign bus.halted     = (state_q == S_HALT);
   assign bus.trap_cause = trap_cause_q;
endmodule

// File: tb/tb_core_ctrl.sv
// Randomized bench for core_ctrl: a reactive memory responder plus an
// instruction-level reference model of PC, strobes, latency and traps.
module tb_core_ctrl;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam int          BUDGET   = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [31:0] exp_pc = RESET_PC;

   logic s_ireq, s_irld, s_dreq, s_dwe, s_rfwe, s_sel, s_iret;

   core_ctrl_if #(.XLEN(32)) bus ();

   core_ctrl #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clr_hs();
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.dmem_gnt    = 1'b0;
      bus.dmem_rvalid = 1'b0;
   endtask

   task automatic set_dec(input bit ill, input bit ebrk, input bit ld, input bit st,
                          input bit br, input logic [31:0] tgt, input bit rdwe);
      bus.dec_illegal   = ill;
      bus.dec_ebreak    = ebrk;
      bus.dec_load      = ld;
      bus.dec_store     = st;
      bus.exu_pc_branch = br;
      bus.exu_target_pc = tgt;
      bus.dec_rd_we     = rdwe;
   endtask

   // One clock with fixed handshake inputs; outputs captured at the falling edge.
   task automatic tick(input bit ig, input bit irv, input bit dg, input bit drv);
      bus.imem_gnt    = ig;
      bus.imem_rvalid = irv;
      bus.dmem_gnt    = dg;
      bus.dmem_rvalid = drv;
      @(negedge clk);
      s_ireq = bus.imem_req;  s_irld = bus.ir_load;  s_dreq = bus.dmem_req;
      s_dwe  = bus.dmem_we;   s_rfwe = bus.rf_we;    s_sel  = bus.rd_sel_mem;
      s_iret = bus.instret;
      @(posedge clk);
      #1;
      clr_hs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clr_hs();
      @(negedge clk);
      chk_eq("rst_imem_req", 32'(bus.imem_req), 0);
      chk_eq("rst_strobes", 32'({bus.ir_load, bus.dmem_req, bus.dmem_we, bus.rf_we,
                                 bus.rd_sel_mem, bus.instret}), 0);
      chk_eq("rst_pc", bus.pc, RESET_PC);
      chk_eq("rst_halted", 32'(bus.halted), 0);
      chk_eq("rst_cause", 32'(bus.trap_cause), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      exp_pc = RESET_PC;
   endtask

   // While halted, random handshakes must produce no activity and leave the PC alone.
   task automatic halt_hold(input logic [1:0] cause);
      int strb = 0;
      int pc_bad = 0;
      for (int i = 0; i < 6; i++) begin
         bus.imem_gnt    = 1'($urandom_range(0, 1));
         bus.imem_rvalid = 1'($urandom_range(0, 1));
         bus.dmem_gnt    = 1'($urandom_range(0, 1));
         bus.dmem_rvalid = 1'($urandom_range(0, 1));
         @(negedge clk);
         strb += int'(bus.imem_req) + int'(bus.ir_load) + int'(bus.dmem_req) + int'(bus.dmem_we)
               + int'(bus.rf_we) + int'(bus.rd_sel_mem) + int'(bus.instret);
         if (bus.pc !== exp_pc) pc_bad++;
         @(posedge clk);
         #1;
      end
      clr_hs();
      chk_eq("halt_strobes", 32'(strb), 0);
      chk_eq("halt_pc_moves", 32'(pc_bad), 0);
      chk_eq("halt_flag", 32'(bus.halted), 1);
      chk_eq("halt_cause", 32'(bus.trap_cause), 32'(cause));
   endtask

   // One instruction from FETCH to retire/halt, with a reactive memory responder.
   task automatic run_instr(input bit ill, input bit ebrk, input bit ld, input bit st,
                            input bit br, input logic [31:0] tgt, input bit rdwe,
                            input int gi_in, input int ri, input int gd_in, input int rdl);
      int gi = gi_in;
      int gd = gd_in;
      int cyc = 0;
      bit done = 1'b0;
      bit i_act = 1'b0, d_act = 1'b0;
      int i_cnt = 0, d_cnt = 0;
      int n_ireq = 0, n_irld = 0, n_dreq = 0, n_dwe = 0, n_rfwe = 0, n_sel = 0, n_iret = 0;
      logic [1:0]  cause;
      bit          trap, mem;
      int          e_cyc;
      logic [31:0] e_pc;

      cause = ill ? 2'd2 : ebrk ? 2'd1 : (ld || st) ? 2'd0 : (br && tgt[1]) ? 2'd3 : 2'd0;
      trap  = (cause != 2'd0);
      mem   = !trap && (ld || st);
      e_cyc = (gi + 1) + (ri + 1) + 1 + (trap ? 1 : mem ? (gd + 1) + (ld ? rdl + 1 : 0) : 0);
      e_pc  = trap ? exp_pc : (mem || !br) ? exp_pc + 32'd4 : {tgt[31:1], 1'b0};

      set_dec(ill, ebrk, ld, st, br, tgt, rdwe);
      while (!done && cyc < BUDGET) begin
         bus.imem_rvalid = 1'b0;
         if (i_act) begin
            if (i_cnt == 0) begin bus.imem_rvalid = 1'b1; i_act = 1'b0; end
            else i_cnt--;
         end else bus.imem_rvalid = 1'($urandom_range(0, 1));
         bus.imem_gnt = 1'b0;
         if (bus.imem_req) begin
            if (gi == 0) begin bus.imem_gnt = 1'b1; i_act = 1'b1; i_cnt = ri; gi = -1; end
            else if (gi > 0) gi--;
         end else bus.imem_gnt = 1'($urandom_range(0, 1));

         bus.dmem_rvalid = 1'b0;
         if (d_act) begin
            if (d_cnt == 0) begin bus.dmem_rvalid = 1'b1; d_act = 1'b0; end
            else d_cnt--;
         end else bus.dmem_rvalid = 1'($urandom_range(0, 1));
         bus.dmem_gnt = 1'b0;
         if (bus.dmem_req) begin
            if (gd == 0) begin bus.dmem_gnt = 1'b1; d_act = 1'b1; d_cnt = rdl; gd = -1; end
            else if (gd > 0) gd--;
         end else bus.dmem_gnt = 1'($urandom_range(0, 1));

         @(negedge clk);
         n_ireq += int'(bus.imem_req);  n_irld += int'(bus.ir_load);
         n_dreq += int'(bus.dmem_req);  n_dwe  += int'(bus.dmem_we);
         n_rfwe += int'(bus.rf_we);     n_sel  += int'(bus.rd_sel_mem);
         n_iret += int'(bus.instret);
         if (bus.instret || bus.halted) done = 1'b1;
         @(posedge clk);
         #1;
         cyc++;
      end
      clr_hs();

      chk_eq("completes", 32'(done), 1);
      chk_eq("cycles", 32'(cyc), 32'(e_cyc));
      chk_eq("imem_req_cycles", 32'(n_ireq), 32'(gi_in + 1));
      chk_eq("ir_load_pulses", 32'(n_irld), 1);
      chk_eq("dmem_req_cycles", 32'(n_dreq), mem ? 32'(gd_in + 1) : 0);
      chk_eq("dmem_we_cycles", 32'(n_dwe), (mem && st) ? 32'(gd_in + 1) : 0);
      chk_eq("rf_we_pulses", 32'(n_rfwe), (!trap && !(mem && st)) ? 32'(rdwe) : 0);
      chk_eq("rd_sel_mem_pulses", 32'(n_sel), (mem && ld) ? 1 : 0);
      chk_eq("instret_pulses", 32'(n_iret), trap ? 0 : 1);
      chk_eq("pc", bus.pc, e_pc);
      exp_pc = e_pc;
      if (trap) begin
         halt_hold(cause);
         do_reset();
      end
   endtask

   initial begin
      bit ill, ebrk, ld, st, br, rdwe;
      int m;
      logic [31:0] tgt;

      clr_hs();
      set_dec(0, 0, 0, 0, 0, 32'h0, 0);
      do_reset();

      // Request must be up in the first clock after reset, and hold without a grant.
      tick(0, 0, 0, 0);
      chk_eq("first_imem_req", 32'(s_ireq), 1);

      run_instr(0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0);              // ADDI
      run_instr(0, 0, 0, 0, 1, 32'h8000_0101, 1, 0, 0, 0, 0);      // JAL, bit0 cleared
      run_instr(0, 0, 1, 0, 0, 32'h0, 1, 0, 0, 3, 2);              // slow load
      run_instr(0, 0, 0, 1, 0, 32'h0, 1, 0, 0, 0, 0);              // store
      run_instr(0, 0, 0, 0, 1, 32'hFFFF_FFFD, 0, 0, 0, 0, 0);      // jump to top of space
      run_instr(0, 0, 0, 0, 0, 32'h0, 1, 1, 1, 0, 0);              // pc wraps to 0
      run_instr(0, 0, 0, 0, 1, 32'h8000_0102, 1, 0, 0, 0, 0);      // misaligned target
      run_instr(1, 1, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0);              // illegal beats ebreak
      run_instr(0, 1, 1, 0, 0, 32'h0, 1, 0, 0, 0, 0);              // ebreak beats load

      // Reset while waiting on load data, then stale returns land in FETCH.
      set_dec(0, 0, 1, 0, 0, 32'h0, 1);
      tick(1, 0, 0, 0);
      tick(0, 1, 0, 0);
      chk_eq("mid_ir_load", 32'(s_irld), 1);
      tick(0, 0, 0, 0);
      tick(0, 0, 1, 0);
      chk_eq("mid_dmem_req", 32'(s_dreq), 1);
      tick(0, 0, 0, 0);
      chk_eq("mid_wait_quiet", 32'({s_dreq, s_rfwe, s_iret}), 0);
      set_dec(0, 0, 0, 0, 0, 32'h0, 1);
      do_reset();
      tick(0, 1, 0, 1);
      chk_eq("stale_imem_req", 32'(s_ireq), 1);
      chk_eq("stale_strobes", 32'({s_irld, s_rfwe, s_sel, s_iret}), 0);
      chk_eq("stale_pc", bus.pc, RESET_PC);
      run_instr(0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 0, 0);

      for (int n = 0; n < 200; n++) begin
         ill  = ($urandom_range(0, 24) == 0);
         ebrk = ($urandom_range(0, 24) == 0);
         m    = int'($urandom_range(0, 2));
         ld   = (m == 1);
         st   = (m == 2);
         br   = 1'($urandom_range(0, 1));
         tgt  = $urandom;
         tgt[1] = br && ($urandom_range(0, 7) == 0);
         rdwe = 1'($urandom_range(0, 1));
         run_instr(ill, ebrk, ld, st, br, tgt, rdwe,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/core_ctrl.md
# core_ctrl

Multi-cycle sequencer for the single-issue core. It owns the architectural PC, orders the instruction-memory and data-memory handshakes, and issues the register-file write and instruction-register load strobes around the combinational decode/execute datapath. It sits between IFU/LSU memory ports and the IDU/EXU, and consumes the EXU branch outputs (`pc_branch`, `target_pc`) to choose the next PC.

## Interface
- XLEN, 32, datapath and PC width
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- One clock; reset is asynchronous and active-high.
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- imem_req  out  1  instruction fetch request; address is `pc`
- imem_gnt  in  1  fetch request accepted this cycle
- imem_rvalid  in  1  fetch data valid (earliest: cycle after gnt)
- ir_load  out  1  latch instruction register
- dec_rd_we  in  1  decoded instruction writes rd
- dec_load  in  1  decoded load
- dec_store  in  1  decoded store
- dec_ebreak  in  1  decoded EBREAK
- dec_illegal  in  1  decoded illegal instruction
- exu_pc_branch  in  1  EXU redirect request (jump/taken branch)
- exu_target_pc  in  XLEN  EXU redirect target
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- dmem_gnt  in  1  data request accepted
- dmem_rvalid  in  1  load data valid (earliest: cycle after gnt)
- rf_we  out  1  register-file write strobe
- rd_sel_mem  out  1  rd write data from load data (1) or EXU `rd_wdata` (0)
- pc  out  XLEN  architectural PC
- instret  out  1  one-cycle pulse per retired instruction
- halted  out  1  core stopped
- trap_cause  out  2  0 none, 1 EBREAK, 2 illegal, 3 misaligned jump target

## Operation
- States: FETCH, WAIT_IR, EXEC, MEM, WAIT_MEM, HALT. Reset state FETCH.
- FETCH: imem_req=1, held until imem_gnt; on gnt -> WAIT_IR. imem_rvalid ignored here.
- WAIT_IR: on imem_rvalid, ir_load=1 -> EXEC; else wait.
- EXEC (decode/EXU outputs are stable from IR), priority order:
  - dec_illegal -> HALT, trap_cause=2.
  - dec_ebreak -> HALT, trap_cause=1.
  - dec_load or dec_store -> MEM.
  - exu_pc_branch and exu_target_pc[1]=1 -> HALT, trap_cause=3, no rf write.
  - Otherwise retire: rf_we=dec_rd_we, rd_sel_mem=0, instret=1, pc <= exu_pc_branch ? {exu_target_pc[XLEN-1:1],1'b0} : pc+4 -> FETCH.
- MEM: dmem_req=1, dmem_we=dec_store, held until dmem_gnt. On gnt: store retires (instret=1, pc<=pc+4) -> FETCH; load -> WAIT_MEM.
- WAIT_MEM: on dmem_rvalid: rf_we=dec_rd_we, rd_sel_mem=1, instret=1, pc<=pc+4 -> FETCH.
- HALT: all strobes 0, halted=1, pc frozen; exits only by reset.
- PC arithmetic modulo 2^XLEN; pc+4 wraps silently from all-ones region.
- rf_we, ir_load, instret, dmem_we asserted only in the cycles stated above; never two instret in consecutive cycles.

## Timing
- Reset values: pc=RESET_PC, state FETCH, trap_cause=0, halted=0; imem_req, ir_load, dmem_req, dmem_we, rf_we, rd_sel_mem, instret all 0 while rst=1.
- First imem_req in the first clock after rst deasserts.
- Request outputs are Moore (decoded from state); rf_we/ir_load/instret are Mealy on the accepting handshake input.
- Latency with gnt same cycle as req and rvalid next cycle: ALU/jump 3 cycles, store 4, load 5 (FETCH→FETCH).
- Reset mid-transaction: immediate return to FETCH/RESET_PC; late imem_rvalid/dmem_rvalid after reset is dropped (arrives in FETCH).
- imem_gnt/dmem_gnt outside FETCH/MEM ignored.

## Test plan
- Reset then zero-wait memory, ADDI (dec_rd_we=1): imem_req at cycle 1, rf_we+instret at cycle 3, pc 0x8000_0000 -> 0x8000_0004.
- JAL with exu_target_pc=0x8000_0101: pc becomes 0x8000_0100, rf_we=1, rd_sel_mem=0; target 0x8000_0102 -> HALT, trap_cause=3, rf_we never asserted.
- Load with dmem_gnt delayed 3 cycles and rvalid 2 more: dmem_req held 4 cycles, rf_we+rd_sel_mem single pulse on rvalid, total 10 cycles, pc+4.
- Store: dmem_we=1 with dmem_req, instret on gnt cycle, no rf_we, next state FETCH.
- dec_illegal and dec_ebreak both high: trap_cause=2, halted=1, further imem_gnt/rvalid produce no outputs, pc frozen.
- Assert rst in WAIT_MEM, release, inject stale dmem_rvalid/imem_rvalid in FETCH: no rf_we, no ir_load, pc=RESET_PC, fetch restarts normally.
